// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M execution unit for the EX stage.
// Multiplies complete after MUL_LATENCY cycles. Divides and remainders use
// 32 restoring iterations followed by one sign-fix cycle. A zero divisor and
// signed overflow finish after a single cycle. Results are returned through a
// one-cycle done_o pulse, and result_o holds its value until the next request.
module rv32_muldiv_unit #(
  parameter int MUL_LATENCY = 2,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [4:0] {
    ALU_MUL    = 5'b01010,
    ALU_MULH   = 5'b01011,
    ALU_MULHSU = 5'b01100,
    ALU_MULHU  = 5'b01101,
    ALU_DIV    = 5'b01110,
    ALU_DIVU   = 5'b01111,
    ALU_REM    = 5'b10000,
    ALU_REMU   = 5'b10001
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_SPECIAL,
    S_DONE
  } state_e;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  alu_op_e         op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;

  // Request decode, evaluated on the raw inputs in IDLE.
  logic            op_legal, in_mul, in_signed_div, in_special, accept;
  logic [XLEN-1:0] a_mag_in;

  assign op_legal      = (op_i >= ALU_MUL) && (op_i <= ALU_REMU);
  assign in_mul        = (op_i <= ALU_MULHU);
  assign in_signed_div = (op_i == ALU_DIV) || (op_i == ALU_REM);
  assign in_special    = (b_i == '0) ||
                         (in_signed_div && a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1);
  assign accept        = (state_q == S_IDLE) && valid_i && !flush_i && op_legal;
  assign a_mag_in      = (in_signed_div && a_i[XLEN-1]) ? -a_i : a_i;

  // Latched-operand decode.
  logic            q_signed, a_neg, b_neg, q_is_quot;
  logic [XLEN-1:0] b_mag;

  assign q_signed  = (op_q == ALU_DIV) || (op_q == ALU_REM);
  assign q_is_quot = (op_q == ALU_DIV) || (op_q == ALU_DIVU);
  assign a_neg     = q_signed && a_q[XLEN-1];
  assign b_neg     = q_signed && b_q[XLEN-1];
  assign b_mag     = b_neg ? -b_q : b_q;

  // Multiplier: extend each operand according to its signedness. The low
  // half of the product is the same for every extension, so MUL works too.
  logic [2*XLEN-1:0] a_ext, b_ext, product;
  logic [XLEN-1:0]   mul_res;

  assign a_ext   = {{XLEN{a_q[XLEN-1] && (op_q == ALU_MULH || op_q == ALU_MULHSU)}}, a_q};
  assign b_ext   = {{XLEN{b_q[XLEN-1] && (op_q == ALU_MULH)}}, b_q};
  assign product = a_ext * b_ext;
  assign mul_res = (op_q == ALU_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // One restoring-division step: shift in the next dividend bit, then
  // subtract the divisor if the partial remainder is large enough.
  logic [XLEN:0]   shifted, diff;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step;

  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign diff     = shifted - {1'b0, b_mag};
  assign ge       = !diff[XLEN];
  assign rem_step = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], ge};

  // Sign fix: the quotient sign is the XOR of the operand signs, and the
  // remainder takes the dividend's sign. This gives truncation toward zero.
  logic [XLEN-1:0] fix_res, special_res;

  assign fix_res = q_is_quot ? ((a_neg ^ b_neg) ? -quo_q : quo_q)
                             : (a_neg ? -rem_q : rem_q);

  // Special cases: a zero divisor, or the signed overflow MIN / -1.
  assign special_res = (b_q == '0) ? (q_is_quot ? '1 : a_q)
                                   : (q_is_quot ? a_q : '0);

  // Next-state logic for the FSM and the iteration datapath.
  always_comb begin
    // NOTE: every _d is given its hold value first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = alu_op_e'(op_i);
          a_d   = a_i;
          b_d   = b_i;
          cnt_d = '0;
          quo_d = a_mag_in;
          rem_d = '0;
          if (in_mul)          state_d = S_MUL;
          else if (in_special) state_d = S_SPECIAL;
          else                 state_d = S_DIV;
        end
      end
      S_MUL: begin
        if (cnt_q == MUL_LAST) begin
          result_d = mul_res;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DIV: begin
        quo_d = quo_step;
        rem_d = rem_step;
        if (cnt_q == DIV_LAST) state_d = S_FIX;
        else                   cnt_d   = cnt_q + 6'd1;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_SPECIAL: begin
        result_d = special_res;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A flush aborts any working state. The DONE state finishes its pulse anyway.
    if (flush_i && state_q != S_IDLE && state_q != S_DONE) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Operand and iteration registers.
  always_ff @(posedge clk) begin
    // NOTE: these registers are left out of reset on purpose. They are always loaded at acceptance before anything reads them.
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    quo_q <= quo_d;
    rem_q <= rem_d;
  end

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Self-checking bench for rv32_muldiv_unit. The driver issues requests and
// pushes the expected result and completion edge into a scoreboard. A monitor
// on the falling edge compares ready/busy/done/result against that model.
module tb_rv32_muldiv_unit;

  localparam int MUL_LAT = 2;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b01110;
  localparam logic [4:0] OP_DIVU   = 5'b01111;
  localparam logic [4:0] OP_REM    = 5'b10000;
  localparam logic [4:0] OP_REMU   = 5'b10001;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        ready_o, busy_o, done_o;
  logic [31:0] result_o;

  rv32_muldiv_unit #(.MUL_LATENCY(MUL_LAT), .XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    int unsigned edge_exp;
    logic [4:0]  op;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned ready_edge  = 0;
  logic [31:0] last_result = '0;
  bit          mon_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic bit is_overflow(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Reference model built from the arithmetic definitions.
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      OP_MUL:    begin p = 64'(sa * sb);       return p[31:0];  end
      OP_MULH:   begin p = 64'(sa * sb);       return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub;            return p[63:32]; end
      OP_DIV: begin
        if (b == 0)                  return 32'hFFFF_FFFF;
        if (is_overflow(op, a, b))   return 32'h8000_0000;
        return 32'(sa / sb);
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0)                  return a;
        if (is_overflow(op, a, b))   return 32'h0;
        return 32'(sa % sb);
      end
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int unsigned ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op <= OP_MULHU)                     return MUL_LAT;
    if (b == 0 || is_overflow(op, a, b))    return 1;
    return 33;
  endfunction

  // Monitor: compare the outputs against the model in every cycle.
  always @(negedge clk) begin : monitor
    bit   exp_done;
    bit   exp_ready;
    exp_t e;
    if (mon_en) begin
      exp_ready = (edge_cnt >= ready_edge);
      exp_done  = (sb_q.size() > 0) && (sb_q[0].edge_exp == edge_cnt);
      check("ready", 32'(ready_o), 32'(exp_ready));
      check("busy",  32'(busy_o),  32'(!exp_ready));
      check("done",  32'(done_o),  32'(exp_done));
      if (exp_done) begin
        e = sb_q.pop_front();
        check("result", result_o, e.res);
        last_result = e.res;
      end else begin
        check("result_hold", result_o, last_result);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 100) begin
      step();
      n++;
    end
    if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
  endtask

  task automatic push_expected(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int unsigned lat;
    lat        = ref_latency(op, a, b);
    e.res      = ref_result(op, a, b);
    e.edge_exp = edge_cnt + lat;
    e.op       = op;
    sb_q.push_back(e);
    ready_edge = edge_cnt + lat + 1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit fl);
    bit rdy;
    wait_ready();
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    flush_i = fl;
    rdy     = ready_o;
    step();
    valid_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 5'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
    if (rdy && !fl && is_legal(op)) push_expected(op, a, b);
  endtask

  task automatic flush_mid(input int n);
    int unsigned f;
    for (int i = 0; i < n; i++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    f = edge_cnt;
    if (sb_q.size() > 0 && (f - 1) < sb_q[$].edge_exp) begin
      void'(sb_q.pop_back());
      ready_edge = f;
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    last_result = '0;
    ready_edge  = edge_cnt;
  endtask

  task automatic b2b(input int n);
    int          acc   = 0;
    int          guard = 0;
    bit          rdy;
    logic [4:0]  op;
    logic [31:0] a, b;
    op = OP_MUL + 5'($urandom_range(0, 3));
    a  = $urandom;
    b  = $urandom;
    valid_i = 1'b1;
    op_i = op; a_i = a; b_i = b;
    while (acc < n && guard < 200) begin
      rdy = ready_o;
      step();
      guard++;
      if (rdy) begin
        push_expected(op, a, b);
        acc++;
        op = OP_MUL + 5'($urandom_range(0, 3));
        a  = $urandom;
        b  = $urandom;
        op_i = op; a_i = a; b_i = b;
      end
    end
    valid_i = 1'b0;
    if (acc < n) check("b2b_timeout", 32'(acc), 32'(n));
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      step();
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [4:0]  op;
    logic [31:0] a, b;
    int          sel;

    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    op_i = OP_ADD; a_i = '0; b_i = '0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_ready",  32'(ready_o), 32'd1);
    check("rst_busy",   32'(busy_o),  32'd0);
    check("rst_done",   32'(done_o),  32'd0);
    check("rst_result", result_o,     32'd0);
    ready_edge  = edge_cnt;
    last_result = '0;
    mon_en      = 1'b1;

    // Directed multiply and divide vectors.
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(OP_DIV,    32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(OP_REM,    32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(OP_DIVU,   32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(OP_DIVU,   32'd5, 32'd0, 1'b0);
    issue(OP_REM,    32'd5, 32'd0, 1'b0);
    issue(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    drain();

    // Illegal op and flush-with-valid are both ignored.
    issue(OP_ADD, 32'd1, 32'd2, 1'b0);
    issue(OP_DIV, 32'd9, 32'd3, 1'b1);
    repeat (4) step();

    // Flush a divide in flight, then run a short multiply.
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    flush_mid(9);
    issue(OP_MUL, 32'd3, 32'd4, 1'b0);
    drain();

    // Reset in the middle of a divide.
    issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (5) step();
    rst_pulse();
    issue(OP_MUL, 32'd7, 32'd6, 1'b0);
    drain();

    // Back-to-back multiplies with valid held high.
    b2b(4);
    drain();

    // Randomized mix of legal ops, corner operands, illegal ops and flushes.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0)
        op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 9)) : 5'($urandom_range(18, 31));
      else
        op = OP_MUL + 5'($urandom_range(0, 7));
      sel = $urandom_range(0, 5);
      case (sel)
        0:       begin a = $urandom; b = 32'd0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = 32'($signed(8'($urandom))); b = 32'($signed(4'($urandom))); end
        3:       begin a = $urandom; b = 32'($urandom_range(1, 15)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      issue(op, a, b, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 7) == 0) flush_mid($urandom_range(0, 3));
    end
    drain();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
